// File: rtl/venus_soc_pkg.sv
// Shared SoC AXI4 channel types plus the mem2axi master state encoding.
// Field widths match the SoC crossbar: 16-bit address, 32-bit data, 8-bit ID.
package venus_soc_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 16;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int unsigned AXI_ID_WIDTH   = 8;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [1:0]                burst;
    logic                      lock;
    logic [3:0]                cache;
    logic [2:0]                prot;
  } axi_ax_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
    logic                      last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] id;
    logic [1:0]              resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]   id;
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
    logic                      last;
  } axi_r_t;

  typedef struct packed {
    logic    aw_valid;
    axi_ax_t aw;
    logic    w_valid;
    axi_w_t  w;
    logic    b_ready;
    logic    ar_valid;
    axi_ax_t ar;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   ar_ready;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaddr,
    StWdata,
    StWresp,
    StRaddr,
    StRdata,
    StDone
  } mem2axi_state_e;

endpackage

// File: rtl/mem2axi_master_if.sv
// Command/stream to single-ID AXI4 INCR burst master, one transaction in flight.
// Optional MEM2AXI_BOUNDARY_CHK_EN rejects bursts crossing a 4 KB boundary.
module mem2axi_master_if
  import venus_soc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done_valid,
  input  logic                  done_ready,
  output logic                  done_err,
  output axi_req_t              axi_req_o,
  input  axi_resp_t             axi_resp_i
);

  localparam logic [2:0]          AxSize = 3'($clog2(STRB_WIDTH));
  localparam logic [ID_WIDTH-1:0] AxId   = ID_WIDTH'(AXI_ID);

  mem2axi_state_e        r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [7:0]            r_len, w_len_next;
  logic [7:0]            r_cnt, w_cnt_next;
  logic                  r_err, w_err_next;
  logic                  w_last_beat;
  logic                  w_unused;

`ifdef MEM2AXI_BOUNDARY_CHK_EN
  function automatic logic crosses_4k(input logic [ADDR_WIDTH-1:0] addr,
                                      input logic [7:0]            len);
    logic [31:0] first;
    logic [31:0] last;
    first = 32'(addr);
    last  = first + ((32'(len) + 32'd1) << $clog2(STRB_WIDTH)) - 32'd1;
    return (first >> 12) != (last >> 12);
  endfunction
`endif

  // Response IDs are ignored: only one ID is ever outstanding.
  assign w_unused    = ^{axi_resp_i.b.id, axi_resp_i.r.id};
  assign w_last_beat = (r_cnt == r_len);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_len   <= w_len_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_len_next   = r_len;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;
    rd_data      = '0;
    rd_last      = 1'b0;
    done_valid   = 1'b0;
    done_err     = 1'b0;
    axi_req_o    = '0;

    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_addr_next  = cmd_addr;
          w_len_next   = cmd_len;
          w_cnt_next   = '0;
          w_err_next   = 1'b0;
          w_state_next = cmd_write ? StWaddr : StRaddr;
`ifdef MEM2AXI_BOUNDARY_CHK_EN
          if (crosses_4k(cmd_addr, cmd_len)) begin
            w_err_next   = 1'b1;
            w_state_next = StDone;
          end
`endif
        end
      end

      StWaddr: begin
        axi_req_o.aw_valid = 1'b1;
        axi_req_o.aw.id    = AxId;
        axi_req_o.aw.addr  = r_addr;
        axi_req_o.aw.len   = r_len;
        axi_req_o.aw.size  = AxSize;
        axi_req_o.aw.burst = AXI_BURST_INCR;
        if (axi_resp_i.aw_ready) w_state_next = StWdata;
      end

      StWdata: begin
        axi_req_o.w_valid = wr_valid;
        axi_req_o.w.data  = wr_data;
        axi_req_o.w.strb  = wr_strb;
        axi_req_o.w.last  = w_last_beat;
        wr_ready          = axi_resp_i.w_ready;
        if (wr_valid && axi_resp_i.w_ready) begin
          w_cnt_next = r_cnt + 8'd1;
          if (w_last_beat) w_state_next = StWresp;
        end
      end

      StWresp: begin
        axi_req_o.b_ready = 1'b1;
        if (axi_resp_i.b_valid) begin
          w_err_next   = r_err | (axi_resp_i.b.resp != AXI_RESP_OKAY);
          w_state_next = StDone;
        end
      end

      StRaddr: begin
        axi_req_o.ar_valid = 1'b1;
        axi_req_o.ar.id    = AxId;
        axi_req_o.ar.addr  = r_addr;
        axi_req_o.ar.len   = r_len;
        axi_req_o.ar.size  = AxSize;
        axi_req_o.ar.burst = AXI_BURST_INCR;
        if (axi_resp_i.ar_ready) w_state_next = StRdata;
      end

      StRdata: begin
        rd_valid          = axi_resp_i.r_valid;
        rd_data           = axi_resp_i.r.data;
        rd_last           = w_last_beat;
        axi_req_o.r_ready = rd_ready;
        if (axi_resp_i.r_valid && rd_ready) begin
          // A slave rlast out of step with our own count flags a protocol error.
          w_err_next = r_err | (axi_resp_i.r.resp != AXI_RESP_OKAY)
                     | (axi_resp_i.r.last != w_last_beat);
          w_cnt_next = r_cnt + 8'd1;
          if (w_last_beat) w_state_next = StDone;
        end
      end

      StDone: begin
        done_valid = 1'b1;
        done_err   = r_err;
        if (done_ready) w_state_next = StIdle;
      end

      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem2axi_master_if.sv
// Directed bench for mem2axi_master_if; the bench drives the AXI slave side itself.
// Boundary vectors run only when MEM2AXI_BOUNDARY_CHK_EN is defined.
module tb_mem2axi_master_if;
  import venus_soc_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        done_valid, done_ready, done_err;
  axi_req_t    req;
  axi_resp_t   resp;

  int n_vec;
  int n_err;

  mem2axi_master_if u_dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_strb    (wr_strb),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .done_err   (done_err),
    .axi_req_o  (req),
    .axi_resp_i (resp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue a command; returns at the negedge after the IDLE handshake.
  task automatic issue(input logic wr, input logic [15:0] addr, input logic [7:0] len);
    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    check_eq("cmd_ready_idle", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic finish_done(input string tag, input logic exp_err);
    #1;
    check_eq({tag, "_done_valid"}, done_valid, 1'b1);
    check_eq({tag, "_done_err"}, done_err, exp_err);
    done_ready = 1'b1;
    @(negedge aclk);
    done_ready = 1'b0;
    #1;
    check_eq({tag, "_done_clr"}, done_valid, 1'b0);
    check_eq({tag, "_idle_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    logic hs;
    n_vec = 0;
    n_err = 0;
    aresetn = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; wr_strb = 0;
    rd_ready = 0; done_ready = 0;
    resp = '0;

    // Reset state
    repeat (2) @(negedge aclk);
    #1;
    check_eq("rst_aw_valid", req.aw_valid, 1'b0);
    check_eq("rst_ar_valid", req.ar_valid, 1'b0);
    check_eq("rst_w_valid", req.w_valid, 1'b0);
    check_eq("rst_done_valid", done_valid, 1'b0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    check_eq("rst_cmd_ready", cmd_ready, 1'b1);

    // Write len=3 @0x0100, wready always 1
    issue(1'b1, 16'h0100, 8'd3);
    #1;
    check_eq("wr_aw_valid", req.aw_valid, 1'b1);
    check_eq("wr_aw_addr", req.aw.addr, 16'h0100);
    check_eq("wr_aw_len", req.aw.len, 8'd3);
    check_eq("wr_aw_size", req.aw.size, 3'd2);
    check_eq("wr_aw_burst", req.aw.burst, 2'b01);
    check_eq("wr_aw_id", req.aw.id, 8'd0);
    check_eq("wr_no_w_before_aw", wr_ready, 1'b0);
    @(negedge aclk);
    resp.aw_ready = 1'b1;
    #1;
    check_eq("wr_aw_hold", req.aw.addr, 16'h0100);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      resp.aw_ready = 1'b0;
      resp.w_ready  = 1'b1;
      wr_valid      = 1'b1;
      wr_data       = 32'hA000_0000 + 32'(i);
      wr_strb       = 4'hF;
      #1;
      check_eq("wr_w_valid", req.w_valid, 1'b1);
      check_eq("wr_w_data", req.w.data, 32'hA000_0000 + 32'(i));
      check_eq("wr_w_last", req.w.last, (i == 3) ? 1'b1 : 1'b0);
      check_eq("wr_ready", wr_ready, 1'b1);
    end
    @(negedge aclk);
    wr_valid     = 1'b0;
    resp.w_ready = 1'b0;
    #1;
    check_eq("wr_b_ready", req.b_ready, 1'b1);
    check_eq("wr_w_idle", req.w_valid, 1'b0);
    resp.b_valid = 1'b1;
    resp.b.resp  = AXI_RESP_OKAY;
    @(negedge aclk);
    resp.b_valid = 1'b0;
    finish_done("wr_ok", 1'b0);

    // Read len=0 @0x0040
    issue(1'b0, 16'h0040, 8'd0);
    resp.ar_ready = 1'b1;
    #1;
    check_eq("rd0_ar_valid", req.ar_valid, 1'b1);
    check_eq("rd0_ar_addr", req.ar.addr, 16'h0040);
    check_eq("rd0_ar_len", req.ar.len, 8'd0);
    @(negedge aclk);
    resp.ar_ready = 1'b0;
    resp.r_valid  = 1'b1;
    resp.r.data   = 32'hDEAD_BEEF;
    resp.r.last   = 1'b1;
    resp.r.resp   = AXI_RESP_OKAY;
    rd_ready      = 1'b1;
    #1;
    check_eq("rd0_rd_valid", rd_valid, 1'b1);
    check_eq("rd0_rd_data", rd_data, 32'hDEAD_BEEF);
    check_eq("rd0_rd_last", rd_last, 1'b1);
    check_eq("rd0_r_ready", req.r_ready, 1'b1);
    @(negedge aclk);
    resp.r_valid = 1'b0;
    rd_ready     = 1'b0;
    finish_done("rd0", 1'b0);

    // Read len=7 with random gaps; AR held while arready low
    issue(1'b0, 16'h0200, 8'd7);
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq("rd7_ar_valid", req.ar_valid, 1'b1);
      check_eq("rd7_ar_addr", req.ar.addr, 16'h0200);
      check_eq("rd7_ar_len", req.ar.len, 8'd7);
      @(negedge aclk);
    end
    resp.ar_ready = 1'b1;
    @(negedge aclk);
    resp.ar_ready = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < 8 && cyc < 200) begin
      if (!resp.r_valid && $urandom_range(0, 2) != 0) begin
        resp.r_valid = 1'b1;
        resp.r.data  = 32'h0000_1000 + 32'(k);
        resp.r.last  = (k == 7);
      end
      rd_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("rd7_rd_valid", rd_valid, resp.r_valid);
      hs = resp.r_valid && rd_ready;
      if (hs) begin
        check_eq("rd7_rd_data", rd_data, 32'h0000_1000 + 32'(k));
        check_eq("rd7_rd_last", rd_last, (k == 7) ? 1'b1 : 1'b0);
        k++;
      end
      @(negedge aclk);
      if (hs) resp.r_valid = 1'b0;
      cyc++;
    end
    rd_ready = 1'b0;
    check_eq("rd7_beats", 64'(k), 64'd8);
    finish_done("rd7", 1'b0);

    // Write with SLVERR; next command held off until done_ready
    issue(1'b1, 16'h0300, 8'd0);
    resp.aw_ready = 1'b1;
    @(negedge aclk);
    resp.aw_ready = 1'b0;
    resp.w_ready  = 1'b1;
    wr_valid      = 1'b1;
    wr_data       = 32'h1234_5678;
    #1;
    check_eq("slv_w_last", req.w.last, 1'b1);
    @(negedge aclk);
    wr_valid      = 1'b0;
    resp.w_ready  = 1'b0;
    resp.b_valid  = 1'b1;
    resp.b.resp   = AXI_RESP_SLVERR;
    @(negedge aclk);
    resp.b_valid  = 1'b0;
    cmd_valid     = 1'b1;
    cmd_write     = 1'b0;
    cmd_addr      = 16'h0040;
    cmd_len       = 8'd0;
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq("slv_done_valid", done_valid, 1'b1);
      check_eq("slv_done_err", done_err, 1'b1);
      check_eq("slv_cmd_blocked", cmd_ready, 1'b0);
      @(negedge aclk);
    end
    done_ready = 1'b1;
    @(negedge aclk);
    done_ready = 1'b0;
    #1;
    check_eq("slv_cmd_ready_after", cmd_ready, 1'b1);
    @(negedge aclk);
    cmd_valid     = 1'b0;
    resp.ar_ready = 1'b1;
    #1;
    check_eq("slv_next_ar_valid", req.ar_valid, 1'b1);
    @(negedge aclk);
    resp.ar_ready = 1'b0;
    resp.r_valid  = 1'b1;
    resp.r.last   = 1'b1;
    resp.r.resp   = AXI_RESP_OKAY;
    rd_ready      = 1'b1;
    @(negedge aclk);
    resp.r_valid  = 1'b0;
    rd_ready      = 1'b0;
    finish_done("slv_next", 1'b0);

    // Read len=3, slave rlast early on beat 2
    issue(1'b0, 16'h0500, 8'd3);
    resp.ar_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge aclk);
      resp.ar_ready = 1'b0;
      resp.r_valid  = 1'b1;
      resp.r.data   = 32'h5000_0000 + 32'(j);
      resp.r.last   = (j == 1);
      rd_ready      = 1'b1;
      #1;
      check_eq("rlast_rd_last", rd_last, (j == 3) ? 1'b1 : 1'b0);
      check_eq("rlast_no_done", done_valid, 1'b0);
    end
    @(negedge aclk);
    resp.r_valid = 1'b0;
    rd_ready     = 1'b0;
    finish_done("rlast", 1'b1);

`ifdef MEM2AXI_BOUNDARY_CHK_EN
    // Write crossing 4 KB: 0x0FF8 + 16 bytes
    issue(1'b1, 16'h0FF8, 8'd3);
    resp.w_ready = 1'b1;
    wr_valid     = 1'b1;
    #1;
    check_eq("bnd_aw_valid", req.aw_valid, 1'b0);
    check_eq("bnd_wr_ready", wr_ready, 1'b0);
    wr_valid     = 1'b0;
    resp.w_ready = 1'b0;
    finish_done("bnd", 1'b1);
`endif

    // Reset pulsed mid-read
    issue(1'b0, 16'h0600, 8'd3);
    resp.ar_ready = 1'b1;
    @(negedge aclk);
    resp.ar_ready = 1'b0;
    resp.r_valid  = 1'b1;
    resp.r.last   = 1'b0;
    rd_ready      = 1'b1;
    #1;
    check_eq("mrst_rd_valid_pre", rd_valid, 1'b1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check_eq("mrst_rd_valid", rd_valid, 1'b0);
    check_eq("mrst_r_ready", req.r_ready, 1'b0);
    check_eq("mrst_ar_valid", req.ar_valid, 1'b0);
    check_eq("mrst_done_valid", done_valid, 1'b0);
    @(negedge aclk);
    aresetn      = 1'b1;
    resp.r_valid = 1'b0;
    rd_ready     = 1'b0;
    #1;
    check_eq("mrst_cmd_ready", cmd_ready, 1'b1);
    check_eq("mrst_ar_idle", req.ar_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
